seq_shift_unit: RTL and testbench

//  Parametrised, multi-cycle shift unit for the simple CPU datapath. Successor to the 4-bit combinational shifter.

---
 rtl/seq_shift_pkg.sv | 18 +
 rtl/shift_step.sv | 37 +++
 rtl/seq_shift_unit.sv | 91 +++++++++
 tb/tb_seq_shift_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_shift_pkg.sv
// Shared types for the sequential shift unit: shift modes and FSM states.
// Build option SEQ_SHIFT_UNIT_ROTATE_EN selects real ROL for mode 2'b11.
package seq_shift_pkg;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROL = 2'b11
  } shift_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } shift_state_t;

endpackage

// File: rtl/shift_step.sv
// Purpose: one 1-bit shift step on d according to mode. Latency: combinational.
// Backpressure: none. Rotate leg exists only with SEQ_SHIFT_UNIT_ROTATE_EN.
module shift_step
  import seq_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] q,
  output logic             out_bit
);

  always_comb begin
    // LSL is also the fallback, so MODE=11 degrades to LSL without the rotate build
    q       = {d[WIDTH-2:0], 1'b0};
    out_bit = d[WIDTH-1];
    case (shift_mode_t'(mode))
      SH_LSR: begin
        q       = {1'b0, d[WIDTH-1:1]};
        out_bit = d[0];
      end
      SH_ASR: begin
        q       = {d[WIDTH-1], d[WIDTH-1:1]};
        out_bit = d[0];
      end
`ifdef SEQ_SHIFT_UNIT_ROTATE_EN
      SH_ROL: begin
        q       = {d[WIDTH-2:0], d[WIDTH-1]};
        out_bit = d[WIDTH-1];
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/seq_shift_unit.sv
// Purpose: multi-cycle shifter, one bit per clock; macro SEQ_SHIFT_UNIT_ROTATE_EN enables ROL.
// Latency: result valid n+1 cycles after accept; result held in DONE until out_ready.
module seq_shift_unit
  import seq_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [SHW-1:0]   shift,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             carry
);

  shift_state_t     state_q, state_d;
  logic [SHW-1:0]   count_q;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] step_q;
  logic             step_bit;
  logic             accept;
  logic             step_en;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .d       (s),
    .mode    (mode_q),
    .q       (step_q),
    .out_bit (step_bit)
  );

  // Handshakes come straight from registered state, never from inputs
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign step_en   = (state_q == ST_BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = (shift == '0) ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (count_q == SHW'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s       <= '0;
      carry   <= 1'b0;
      count_q <= '0;
      mode_q  <= SH_LSL;
    end else if (accept) begin
      s       <= x;
      carry   <= 1'b0;
      count_q <= shift;
      mode_q  <= mode;
    end else if (step_en) begin
      s       <= step_q;
      carry   <= step_bit;
      count_q <= count_q - SHW'(1);
    end
  end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Self-checking bench for seq_shift_unit (WIDTH=8), scoreboard of expected results.
// Rotate expectations follow SEQ_SHIFT_UNIT_ROTATE_EN.
module tb_seq_shift_unit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [2:0]   shift;
  logic [1:0]   mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         carry;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    int           n;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  seq_shift_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .shift     (shift),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .carry     (carry)
  );

  always #5 clk = ~clk;

  // Closed-form reference of an n-bit shift and its last shifted-out bit
  function automatic void model(input logic [W-1:0] xv, input int n, input logic [1:0] md,
                                output logic [W-1:0] sv, output logic cv);
    logic [1:0] m;
    m = md;
`ifndef SEQ_SHIFT_UNIT_ROTATE_EN
    if (m == 2'b11) m = 2'b00;
`endif
    cv = 1'b0;
    case (m)
      2'b00: begin
        sv = xv << n;
        if (n > 0) cv = xv[W-n];
      end
      2'b01: begin
        sv = xv >> n;
        if (n > 0) cv = xv[n-1];
      end
      2'b10: begin
        sv = W'($signed(xv) >>> n);
        if (n > 0) cv = xv[n-1];
      end
      default: begin
        sv = (xv << n) | (xv >> (W - n));
        if (n > 0) cv = sv[0];
      end
    endcase
  endfunction

  task automatic wait_ready(input string name);
    int t;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_in_ready: got %b want 1", name, in_ready);
    end
  endtask

  // Issue one request, push the expected result, then wait and compare
  task automatic run_op(input logic [W-1:0] xv, input logic [2:0] sh, input logic [1:0] md,
                        input string name);
    exp_t e;
    int   lat;
    wait_ready(name);
    x = xv; shift = sh; mode = md; in_valid = 1'b1;
    model(xv, int'(sh), md, e.s, e.c);
    e.n = int'(sh);
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    x = W'($urandom); shift = 3'($urandom_range(0, 7)); mode = 2'($urandom_range(0, 3));
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    e = sb.pop_front();
    checks++;
    if (lat !== e.n || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles (out_valid=%b) want %0d", name, lat, out_valid, e.n);
    end
    checks++;
    if (s !== e.s) begin
      errors++;
      $display("FAIL %s_s: got %h want %h", name, s, e.s);
    end
    checks++;
    if (carry !== e.c) begin
      errors++;
      $display("FAIL %s_carry: got %b want %b", name, carry, e.c);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_release: out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    checks++;
    if (s !== 8'h00 || carry !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: s=%h carry=%b out_valid=%b in_ready=%b want 00/0/0/1",
               s, carry, out_valid, in_ready);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_lsl;
    run_op(8'h96, 3'd3, 2'b00, "lsl3");
  endtask

  task automatic test_zero_asr;
    run_op(8'hA5, 3'd0, 2'($urandom_range(0, 3)), "zero");
    run_op(8'h81, 3'd1, 2'b10, "asr1");
  endtask

  task automatic test_rotate;
    run_op(8'h81, 3'd7, 2'b11, "mode11");
    run_op(8'h5A, 3'd3, 2'b11, "mode11b");
  endtask

  task automatic test_backpressure;
    exp_t e;
    int   t;
    out_ready = 1'b0;
    wait_ready("bp");
    x = 8'h3C; shift = 3'd2; mode = 2'b01; in_valid = 1'b1;
    model(8'h3C, 2, 2'b01, e.s, e.c);
    e.n = 2;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 50) begin
      @(posedge clk); #1; t++;
    end
    e = sb[0];
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || s !== e.s || carry !== e.c) begin
        errors++;
        $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b s=%h carry=%b want 1/0/%h/%b",
                 i, out_valid, in_ready, s, carry, e.s, e.c);
      end
      in_valid = 1'b1; x = W'($urandom); shift = 3'($urandom_range(1, 7));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    void'(sb.pop_front());
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_midop;
    logic seen;
    wait_ready("rst_mid");
    x = 8'h55; shift = 3'd6; mode = 2'b00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (s !== 8'h00 || carry !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_outputs: s=%h carry=%b out_valid=%b in_ready=%b want 00/0/0/1",
               s, carry, out_valid, in_ready);
    end
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_no_valid: out_valid seen=%b want 0", seen);
    end
    run_op(8'h55, 3'd6, 2'b00, "after_rst");
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 30; i++) begin
      run_op(W'($urandom), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), "b2b");
    end
  endtask

  initial begin
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x         = '0;
    shift     = '0;
    mode      = '0;
    test_reset();
    test_lsl();
    test_zero_asr();
    test_backpressure();
    test_rotate();
    test_reset_midop();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
